// File: rtl/finite_bcd.sv
// Sequential binary-to-BCD splitter: reduces a 7-bit counter value modulo 100 and
// extracts tens/ones digits by repeated subtract-by-ten, one step per clock.

package finite_bcd_pkg;

    localparam int unsigned VAL_W = 7;
    localparam int unsigned DIG_W = 4;
    localparam int unsigned IN_W  = VAL_W + 1;
    localparam int unsigned OUT_W = 3 + 2 * DIG_W;

    typedef struct packed {
        logic             start;
        logic [VAL_W-1:0] value;
    } bcd_in_t;

    typedef struct packed {
        logic             busy;
        logic             done;
        logic             ovf;
        logic [DIG_W-1:0] tens;
        logic [DIG_W-1:0] ones;
    } bcd_out_t;

endpackage

module finite_bcd
    import finite_bcd_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  __in0,
    output logic [OUT_W-1:0] __out0
);

    localparam logic [VAL_W-1:0] TEN     = VAL_W'(10);
    localparam logic [VAL_W-1:0] HUNDRED = VAL_W'(100);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [VAL_W-1:0] rem_q,   rem_d;
    logic [DIG_W-1:0] tcnt_q,  tcnt_d;
    logic             ovf_r_q, ovf_r_d;
    logic [DIG_W-1:0] tens_q,  tens_d;
    logic [DIG_W-1:0] ones_q,  ones_d;
    logic             ovf_q,   ovf_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;

    bcd_in_t  in_w;
    bcd_out_t out_w;
    logic     in_big;

    assign in_w   = bcd_in_t'(__in0);
    assign in_big = (in_w.value >= HUNDRED);

    // Next-state, datapath and output-register decode
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        tcnt_d  = tcnt_q;
        ovf_r_d = ovf_r_q;
        tens_d  = tens_q;
        ones_d  = ones_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (in_w.start) begin
                    // Pre-reduce 100..127 so the loop runs at most nine times
                    rem_d   = in_big ? (in_w.value - HUNDRED) : in_w.value;
                    ovf_r_d = in_big;
                    tcnt_d  = '0;
                    state_d = SUB;
                end else begin
                    state_d = IDLE;
                end
            end
            SUB: begin
                if (rem_q >= TEN) begin
                    rem_d  = rem_q - TEN;
                    tcnt_d = tcnt_q + DIG_W'(1);
                end else begin
                    tens_d  = tcnt_q;
                    ones_d  = rem_q[DIG_W-1:0];
                    ovf_d   = ovf_r_q;
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == SUB);
        done_d = (state_d == DONE);
    end

    // State and output registers, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            rem_q   <= '0;
            tcnt_q  <= '0;
            ovf_r_q <= 1'b0;
            tens_q  <= '0;
            ones_q  <= '0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            tcnt_q  <= tcnt_d;
            ovf_r_q <= ovf_r_d;
            tens_q  <= tens_d;
            ones_q  <= ones_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign out_w.busy = busy_q;
    assign out_w.done = done_q;
    assign out_w.ovf  = ovf_q;
    assign out_w.tens = tens_q;
    assign out_w.ones = ones_q;
    assign __out0     = OUT_W'(out_w);

endmodule
